// File: rtl/reg_client.sv
// Register-access initiator: serialises one request into 8 command bytes, then collects a 4-byte reply.
// Latency: accept -> 8 SEND -> 4 RX -> END -> 1-cycle DONE pulse (14 cycles with no stalls).
// Backpressure: cmd_full stalls SEND indefinitely; reply_rdy/reply_end waits are bounded by TIMEOUT.
module reg_client #(
  parameter logic [7:0] MAGIC   = 8'hAA,
  parameter int         TIMEOUT = 1024,
  parameter int         TW      = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [7:0]  cmd_out,
  output logic        cmd_wr,
  input  logic        cmd_full,
  input  logic [7:0]  reply_in,
  input  logic        reply_rdy,
  output logic        reply_ack,
  input  logic        reply_end,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_RX,
    S_END,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [TW-1:0]  cnt, cnt_nxt;
  logic           wr_q;
  logic [15:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    rdata_q;
  logic [7:0]     tx_byte;
  logic           load_req;
  logic           cap_byte;
  logic           finish;
  logic           fin_err;
  logic           timeout_hit;

  // Last allowed idle cycle: the wait has run out when the counter reaches TIMEOUT-1.
  assign timeout_hit = (cnt == TW'(TIMEOUT - 1));

  // Command byte selected by the send index, from the latched request.
  always_comb begin
    tx_byte = MAGIC;
    case (idx)
      3'd0:    tx_byte = MAGIC;
      3'd1:    tx_byte = {7'b0, wr_q};
      3'd2:    tx_byte = addr_q[7:0];
      3'd3:    tx_byte = addr_q[15:8];
      3'd4:    tx_byte = wdata_q[7:0];
      3'd5:    tx_byte = wdata_q[15:8];
      3'd6:    tx_byte = wdata_q[23:16];
      default: tx_byte = wdata_q[31:24];
    endcase
  end

  // Next-state and handshake outputs; reply_end takes priority over reply_rdy in RX.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    cmd_wr    = 1'b0;
    cmd_out   = 8'h00;
    reply_ack = 1'b0;
    rsp_valid = 1'b0;
    load_req  = 1'b0;
    cap_byte  = 1'b0;
    finish    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_req  = 1'b1;
          idx_nxt   = 3'd0;
          cnt_nxt   = '0;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        cmd_out = tx_byte;
        if (!cmd_full) begin
          cmd_wr  = 1'b1;
          idx_nxt = idx + 3'd1;
          if (idx == 3'd7) begin
            idx_nxt   = 3'd0;
            cnt_nxt   = '0;
            state_nxt = S_RX;
          end
        end
      end
      S_RX: begin
        if (reply_end) begin
          finish    = 1'b1;
          fin_err   = 1'b1;
          state_nxt = S_DONE;
        end else if (reply_rdy) begin
          reply_ack = 1'b1;
          cap_byte  = 1'b1;
          idx_nxt   = idx + 3'd1;
          cnt_nxt   = '0;
          if (idx == 3'd3) begin
            idx_nxt   = 3'd0;
            state_nxt = S_END;
          end
        end else if (timeout_hit) begin
          finish    = 1'b1;
          fin_err   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      S_END: begin
        if (reply_end) begin
          finish    = 1'b1;
          fin_err   = 1'b0;
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          finish    = 1'b1;
          fin_err   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, request latch, reply assembly and the held response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (load_req) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (cap_byte) begin
        rdata_q[8*idx[1:0] +: 8] <= reply_in;
      end
      if (finish) begin
        rsp_err   <= fin_err;
        rsp_rdata <= fin_err ? 32'h0 : rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_reg_client.sv
// Directed plus randomised bench for reg_client with a byte-level responder model.
// Expected command bytes, reply word, error flag and timing are derived from the protocol rules.
// Inputs are driven 1 time unit after the rising edge and outputs sampled on the falling edge.
module tb_reg_client;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [7:0]  cmd_out;
  logic        cmd_wr;
  logic        cmd_full = 1'b0;
  logic [7:0]  reply_in = 8'h0;
  logic        reply_rdy = 1'b0;
  logic        reply_ack;
  logic        reply_end = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] rep [4];

  reg_client #(.MAGIC(8'hAA), .TIMEOUT(TO), .TW(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .cmd_out(cmd_out), .cmd_wr(cmd_wr), .cmd_full(cmd_full),
    .reply_in(reply_in), .reply_rdy(reply_rdy), .reply_ack(reply_ack), .reply_end(reply_end),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request/response exchange. nrep reply bytes are offered, then reply_end if do_end.
  // bp: 0 none, 1 random cmd_full, 2 three-cycle stall after three bytes sent.
  // imm: responder answers with no gaps. rst_at > 0: pulse reset once that many acks are taken.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input int nrep, input bit do_end, input int bp, input bit imm,
                         input int rst_at);
    logic [7:0]  exp_cmd [8];
    logic [7:0]  got_cmd [$];
    logic [63:0] exp64, got64;
    logic [31:0] got_rdata, exp_rdata;
    logic        got_err, exp_err;
    int nsent, nack, gap, full_left, start_cyc, rsp_cyc, last_ack_cyc, nrsp, bad_full, n;
    bit ack_pend, ended;

    exp_cmd = '{8'hAA, {7'b0, wr}, addr[7:0], addr[15:8],
                wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
    exp64 = '0;
    got64 = '0;
    for (int i = 0; i < 8; i++) exp64[8*i +: 8] = exp_cmd[i];
    exp_err   = !(nrep == 4 && do_end);
    exp_rdata = exp_err ? 32'h0 : {rep[3], rep[2], rep[1], rep[0]};
    nsent = 0; nack = 0; full_left = 3; rsp_cyc = -1; last_ack_cyc = 0;
    nrsp = 0; bad_full = 0; ack_pend = 0; ended = 0;
    got_rdata = 32'h0; got_err = 1'b0;
    gap = imm ? 0 : int'($urandom_range(0, 3));

    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    cmd_full = 1'b0; reply_rdy = 1'b0; reply_end = 1'b0;
    start_cyc = cyc;
    @(negedge clk);
    check("req_ready_idle", {63'b0, req_ready}, 64'd1);

    for (int t = 0; t < 2000 && nrsp == 0; t++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_wdata = $urandom;
      reply_end = 1'b0;
      if (ack_pend) begin
        nack++;
        ack_pend  = 1'b0;
        reply_rdy = 1'b0;
        gap = imm ? 0 : int'($urandom_range(0, 3));
      end
      if (rst_at > 0 && nack == rst_at) begin
        reset_n = 1'b0; reply_rdy = 1'b0; cmd_full = 1'b0;
        @(negedge clk);
        check("rst_cmd_wr", {63'b0, cmd_wr}, 64'd0);
        check("rst_reply_ack", {63'b0, reply_ack}, 64'd0);
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
        check("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
        check("rst_req_ready", {63'b0, req_ready}, 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        n = 0;
        repeat (20) begin
          @(negedge clk);
          if (rsp_valid || cmd_wr) n++;
        end
        check("rst_silent", 64'(n), 64'd0);
        return;
      end
      case (bp)
        1: cmd_full = ($urandom_range(0, 3) == 0);
        2: if (nsent == 3 && full_left > 0) begin
             cmd_full = 1'b1;
             full_left--;
           end else cmd_full = 1'b0;
        default: cmd_full = 1'b0;
      endcase
      if (nsent == 8) begin
        if (nack < nrep) begin
          if (!reply_rdy) begin
            if (gap > 0) gap--;
            else begin
              reply_rdy = 1'b1;
              reply_in  = rep[nack];
            end
          end
        end else begin
          // Stray bytes offered after the fourth byte must never be acked.
          if (!imm && nrep == 4) begin
            reply_rdy = 1'($urandom_range(0, 1));
            reply_in  = 8'hEE;
          end else reply_rdy = 1'b0;
          if (do_end && !ended) begin
            if (gap > 0) gap--;
            else begin
              reply_end = 1'b1;
              ended = 1'b1;
            end
          end
        end
      end
      @(negedge clk);
      if (cmd_wr) begin
        if (cmd_full) bad_full++;
        got_cmd.push_back(cmd_out);
        nsent++;
      end
      if (reply_ack) begin
        ack_pend = 1'b1;
        last_ack_cyc = cyc;
      end
      if (rsp_valid) begin
        nrsp++;
        rsp_cyc = cyc;
        got_rdata = rsp_rdata;
        got_err = rsp_err;
      end
    end
    reply_rdy = 1'b0; reply_end = 1'b0; cmd_full = 1'b0;
    @(negedge clk);
    check("req_ready_after_done", {63'b0, req_ready}, 64'd1);
    if (rsp_valid) nrsp++;
    @(negedge clk);
    if (rsp_valid) nrsp++;

    for (int i = 0; i < 8 && i < got_cmd.size(); i++) got64[8*i +: 8] = got_cmd[i];
    check("rsp_count", 64'(nrsp), 64'd1);
    check("cmd_count", 64'(got_cmd.size()), 64'd8);
    check("cmd_bytes", got64, exp64);
    check("cmd_full_respected", 64'(bad_full), 64'd0);
    check("ack_count", 64'(nack + int'(ack_pend)), 64'(nrep));
    check("rsp_err", {63'b0, got_err}, {63'b0, exp_err});
    check("rsp_rdata", {32'b0, got_rdata}, {32'b0, exp_rdata});
    if (!do_end) check("timeout_cycles", 64'(rsp_cyc - (last_ack_cyc + 1)), 64'(TO));
    if (imm && do_end && nrep == 4 && bp == 0) check("latency", 64'(rsp_cyc - start_cyc), 64'd14);
    if (imm && do_end && nrep == 4 && bp == 2) check("latency_bp", 64'(rsp_cyc - start_cyc), 64'd17);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", {63'b0, req_ready}, 64'd1);
    check("reset_cmd_wr", {63'b0, cmd_wr}, 64'd0);
    check("reset_reply_ack", {63'b0, reply_ack}, 64'd0);
    check("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("reset_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
    check("reset_rsp_err", {63'b0, rsp_err}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Stray reply signals in IDLE are ignored.
    @(posedge clk); #1;
    reply_rdy = 1'b1; reply_end = 1'b1; reply_in = 8'h55;
    @(negedge clk);
    check("idle_no_ack", {63'b0, reply_ack}, 64'd0);
    @(posedge clk); #1;
    reply_rdy = 1'b0; reply_end = 1'b0;
    @(negedge clk);
    check("idle_no_rsp", {63'b0, rsp_valid}, 64'd0);
    check("idle_ready", {63'b0, req_ready}, 64'd1);

    // Write, immediate reply 78,56,34,12.
    rep = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_txn(1'b1, 16'h0102, 32'hDEADBEEF, 4, 1'b1, 0, 1'b1, 0);
    // cmd_full stall after the third byte.
    run_txn(1'b0, 16'h0102, 32'h0BADF00D, 4, 1'b1, 2, 1'b1, 0);
    // Two bytes then silence: timeout in RX.
    run_txn(1'b0, 16'h4321, 32'h11112222, 2, 1'b0, 0, 1'b1, 0);
    // Four bytes, no reply_end: timeout in END.
    rep = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_txn(1'b1, 16'hBEEF, 32'hCAFEF00D, 4, 1'b0, 0, 1'b1, 0);
    // Early reply_end after three bytes, then a clean transaction.
    run_txn(1'b0, 16'h0010, 32'h00000000, 3, 1'b1, 0, 1'b1, 0);
    rep = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_txn(1'b1, 16'h0020, 32'h12345678, 4, 1'b1, 0, 1'b0, 0);
    // Reset after two acks, then recover.
    run_txn(1'b1, 16'h0030, 32'h9ABCDEF0, 4, 1'b1, 0, 1'b1, 2);
    rep = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    run_txn(1'b0, 16'h0040, 32'h0F0F0F0F, 4, 1'b1, 0, 1'b1, 0);

    // Randomised traffic with random backpressure and reply gaps.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) rep[i] = 8'($urandom);
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4, 1'b1, 1, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
